// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Optional requester-0 bus lock is compiled in with `define DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] a0,
  input  logic [AW-1:0] a1,
  input  logic [DW-1:0] wd0,
  input  logic [DW-1:0] wd1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rd0,
  output logic [DW-1:0] rd1,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
`ifdef DMEM_ARB_LOCK_EN
  input  logic          lock0,
`endif
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [DW-1:0] rd0_q, rd0_d;
  logic [DW-1:0] rd1_q, rd1_d;
  logic          lock_hold;

`ifdef DMEM_ARB_LOCK_EN
  logic          lock_q, lock_d;
  assign lock_hold = lock_q & lock0 & req0;
`else
  assign lock_hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

`ifdef DMEM_ARB_LOCK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    ack0    = 1'b0;
    ack1    = 1'b0;
    mem_we  = 1'b0;
    mem_a   = '0;
    mem_wd  = '0;
`ifdef DMEM_ARB_LOCK_EN
    lock_d  = lock_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = SERVE;
          // With a single request, req1 itself names the winner.
          if (lock_hold) begin
            gnt_d = 1'b0;
          end else if (req0 && req1) begin
            gnt_d = ~last_q;
          end else begin
            gnt_d = req1;
          end
        end
`ifdef DMEM_ARB_LOCK_EN
        if (!lock0) begin
          lock_d = 1'b0;
        end
`endif
      end
      SERVE: begin
        mem_we  = gnt_q ? we1 : we0;
        mem_a   = gnt_q ? a1  : a0;
        mem_wd  = gnt_q ? wd1 : wd0;
        last_d  = gnt_q;
        state_d = DONE;
        if (gnt_q) begin
          rd1_d = mem_rd;
        end else begin
          rd0_d = mem_rd;
        end
      end
      DONE: begin
        ack0    = ~gnt_q;
        ack1    = gnt_q;
        state_d = IDLE;
`ifdef DMEM_ARB_LOCK_EN
        if (!gnt_q && lock0) begin
          lock_d = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rd0 = rd0_q;
  assign rd1 = rd1_q;

endmodule
